led_pattern_gen: RTL



---
 rtl/led_pattern_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: prescaled up/down/bounce/breathe patterns with pause and single-step
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 25,
  parameter int DIV_TERM = 24999999,
  parameter int PWM_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [2:0]       speed,
  input  logic             pause,
  input  logic             step,
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam logic [DIV_W-1:0] DIV_TERM_C = DIV_W'(DIV_TERM);
  localparam logic [PWM_W-1:0] DUTY_MAX   = '1;

  logic [DIV_W-1:0] term;
  logic             adv;
  logic             mode_chg;

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             ramp_q, ramp_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  mode_e            mode_q, mode_d;
  logic             step_q, step_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             tick_q, tick_d;

  // Shift amounts at or beyond DIV_W naturally yield a terminal count of zero.
  assign term     = DIV_TERM_C >> speed;
  assign mode_chg = (mode_e'(mode) != mode_q);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    ramp_d  = ramp_q;
    pwm_d   = pwm_q;
    mode_d  = mode_q;
    step_d  = step_q;
    leds_d  = '0;
    tick_d  = 1'b0;
    adv     = 1'b0;

    if (en) begin
      step_d = step;
      mode_d = mode_e'(mode);
      pwm_d  = pwm_q + PWM_W'(1);

      if (mode_chg) begin
        presc_d = '0;
        cnt_d   = (mode_e'(mode) == MODE_DOWN) ? '1 : '0;
        pos_d   = WIDTH'(1);
        dir_d   = 1'b0;
        duty_d  = '0;
        ramp_d  = 1'b0;
      end else begin
        if (!pause) begin
          if (presc_q == term) begin
            presc_d = '0;
            adv     = 1'b1;
          end else if (presc_q > term) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end else begin
          adv = step & ~step_q;
        end

        if (adv) begin
          case (mode_q)
            MODE_UP:   cnt_d = cnt_q + WIDTH'(1);
            MODE_DOWN: cnt_d = cnt_q - WIDTH'(1);
            MODE_BOUNCE: begin
              // dir_q=0 moves toward the MSB; endpoints turn around without repeating.
              if (WIDTH == 1) begin
                pos_d = pos_q;
              end else if (!dir_q) begin
                if (pos_q[WIDTH-1]) begin
                  pos_d = pos_q >> 1;
                  dir_d = 1'b1;
                end else begin
                  pos_d = pos_q << 1;
                end
              end else begin
                if (pos_q[0]) begin
                  pos_d = pos_q << 1;
                  dir_d = 1'b0;
                end else begin
                  pos_d = pos_q >> 1;
                end
              end
            end
            default: begin
              if (!ramp_q) begin
                if (duty_q == DUTY_MAX) begin
                  duty_d = duty_q - PWM_W'(1);
                  ramp_d = 1'b1;
                end else begin
                  duty_d = duty_q + PWM_W'(1);
                end
              end else begin
                if (duty_q == '0) begin
                  duty_d = duty_q + PWM_W'(1);
                  ramp_d = 1'b0;
                end else begin
                  duty_d = duty_q - PWM_W'(1);
                end
              end
            end
          endcase
        end
      end

      tick_d = adv;
      case (mode_q)
        MODE_UP, MODE_DOWN: leds_d = cnt_q;
        MODE_BOUNCE:        leds_d = pos_q;
        default:            leds_d = {WIDTH{pwm_q < duty_q}};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      pos_q   <= WIDTH'(1);
      dir_q   <= 1'b0;
      duty_q  <= '0;
      ramp_q  <= 1'b0;
      pwm_q   <= '0;
      mode_q  <= MODE_UP;
      step_q  <= 1'b0;
      leds_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      ramp_q  <= ramp_d;
      pwm_q   <= pwm_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      leds_q  <= leds_d;
      tick_q  <= tick_d;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule
